// File: rtl/multicycle_control_v2.sv
// multicycle_control_v2: RV32I multicycle control FSM with memory handshake and illegal-instruction trap.
// Define CTRL_INSTRET_EN to add the o_instret retired-instruction counter.
module multicycle_control_v2 #(
    parameter int ALUCTRL_W = 4
`ifdef CTRL_INSTRET_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [31:0]          i_instr,
    input  logic                 i_zero,
    input  logic                 i_lt,
    input  logic                 i_ltu,
    input  logic                 i_mem_ready,
    output logic                 o_PCWrite,
    output logic                 o_AdrSrc,
    output logic                 o_MemRead,
    output logic                 o_MemWrite,
    output logic                 o_IRWrite,
    output logic                 o_RegWrite,
    output logic [1:0]           o_ResultSrc,
    output logic [1:0]           o_ALUSrcA,
    output logic [1:0]           o_ALUSrcB,
    output logic [ALUCTRL_W-1:0] o_ALUControl,
    output logic [2:0]           o_ImmSrc,
    output logic                 o_illegal,
    output logic [3:0]           o_state
`ifdef CTRL_INSTRET_EN
    , output logic [CNT_W-1:0]   o_instret
`endif
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, JALRPC, UPPER, TRAP
    } state_t;
    state_t state, nxt, dec;
    logic [6:0] op, f7;
    logic [2:0] f3, imm;
    logic [3:0] alu;
    logic legal, taken, unused_bits;
    assign op = i_instr[6:0];
    assign f3 = i_instr[14:12];
    assign f7 = i_instr[31:25];
    assign unused_bits = ^{i_instr[24:15], i_instr[11:7]};
    assign o_state = state;
    assign o_ImmSrc = i_rst ? 3'd0 : imm;
    always_comb begin
        legal = 1'b1;
        dec = TRAP;
        imm = 3'd0;
        case (op)
            7'h03: begin legal = f3 != 3'd3 && f3 < 3'd6; dec = MEMADR; end
            7'h23: begin legal = f3 < 3'd3; dec = MEMADR; imm = 3'd1; end
            7'h33: begin legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)); dec = EXECR; end
            7'h13: dec = EXECI;
            7'h63: begin legal = f3 != 3'd2 && f3 != 3'd3; dec = BRANCH; imm = 3'd2; end
            7'h6F: begin dec = JAL; imm = 3'd3; end
            7'h67: dec = JALR;
            7'h37, 7'h17: begin dec = UPPER; imm = 3'd4; end
            default: legal = 1'b0;
        endcase
    end
    // funct7[5] selects SUB only for R-type; SRA/SRAI use it in both formats
    always_comb begin
        case (f3)
            3'b000:  alu = (state == EXECR && f7[5]) ? 4'd1 : 4'd0;
            3'b001:  alu = 4'd7;
            3'b010:  alu = 4'd5;
            3'b011:  alu = 4'd6;
            3'b100:  alu = 4'd4;
            3'b101:  alu = f7[5] ? 4'd9 : 4'd8;
            3'b110:  alu = 4'd3;
            default: alu = 4'd2;
        endcase
    end
    always_comb begin
        case (f3)
            3'b000:  taken = i_zero;
            3'b001:  taken = !i_zero;
            3'b100:  taken = i_lt;
            3'b101:  taken = !i_lt;
            3'b110:  taken = i_ltu;
            default: taken = !i_ltu;
        endcase
    end
    always_comb begin
        nxt = state;
        case (state)
            FETCH:                    nxt = i_mem_ready ? DECODE : FETCH;
            DECODE:                   nxt = legal ? dec : TRAP;
            MEMADR:                   nxt = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:                  nxt = i_mem_ready ? MEMWB : MEMREAD;
            MEMWRITE:                 nxt = i_mem_ready ? FETCH : MEMWRITE;
            EXECR, EXECI, JAL, UPPER: nxt = ALUWB;
            JALR:                     nxt = JALRPC;
            TRAP:                     nxt = TRAP;
            default:                  nxt = FETCH;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) state <= FETCH;
        else state <= nxt;
`ifdef CTRL_INSTRET_EN
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) o_instret <= '0;
        else if (nxt == FETCH && state != FETCH) o_instret <= o_instret + CNT_W'(1);
`endif
    // Gating with i_rst drops every enable the instant reset rises, even mid-handshake
    always_comb begin
        o_PCWrite = 1'b0;
        o_AdrSrc = 1'b0;
        o_MemRead = 1'b0;
        o_MemWrite = 1'b0;
        o_IRWrite = 1'b0;
        o_RegWrite = 1'b0;
        o_ResultSrc = 2'b00;
        o_ALUSrcA = 2'b00;
        o_ALUSrcB = 2'b00;
        o_ALUControl = '0;
        o_illegal = 1'b0;
        if (!i_rst)
            case (state)
                FETCH:    begin o_MemRead = 1'b1; o_IRWrite = i_mem_ready; o_PCWrite = i_mem_ready; o_ALUSrcB = 2'b10; o_ResultSrc = 2'b10; end
                DECODE:   begin o_ALUSrcA = 2'b01; o_ALUSrcB = 2'b01; end
                MEMADR:   begin o_ALUSrcA = 2'b10; o_ALUSrcB = 2'b01; end
                MEMREAD:  begin o_AdrSrc = 1'b1; o_MemRead = 1'b1; end
                MEMWB:    begin o_ResultSrc = 2'b01; o_RegWrite = 1'b1; end
                MEMWRITE: begin o_AdrSrc = 1'b1; o_MemWrite = 1'b1; end
                EXECR:    begin o_ALUSrcA = 2'b10; o_ALUControl = ALUCTRL_W'(alu); end
                EXECI:    begin o_ALUSrcA = 2'b10; o_ALUSrcB = 2'b01; o_ALUControl = ALUCTRL_W'(alu); end
                ALUWB:    o_RegWrite = 1'b1;
                BRANCH:   begin o_ALUSrcA = 2'b10; o_ALUControl = ALUCTRL_W'(1); o_PCWrite = taken; end
                JAL:      begin o_ALUSrcA = 2'b01; o_ALUSrcB = 2'b10; o_PCWrite = 1'b1; end
                JALR:     begin o_ALUSrcA = 2'b10; o_ALUSrcB = 2'b01; o_ResultSrc = 2'b11; o_RegWrite = 1'b1; end
                JALRPC:   o_PCWrite = 1'b1;
                UPPER:    begin o_ALUSrcA = op[5] ? 2'b11 : 2'b01; o_ALUSrcB = 2'b01; end
                TRAP:     o_illegal = 1'b1;
                default:  ;
            endcase
    end
endmodule

// File: tb/tb_multicycle_control_v2.sv
// tb_multicycle_control_v2: directed and randomized checks of the control FSM against an
// instruction-sequence model of the multicycle core.
module tb_multicycle_control_v2;
`ifdef CTRL_INSTRET_EN
    localparam int CW = 4;
    logic [CW-1:0] instret;
`endif
    logic clk = 0, rst = 1, zero = 0, lt = 0, ltu = 0, rdy = 0;
    logic [31:0] instr = 0, opa = 0, opb = 0;
    logic pcw, adr, mrd, mwr, irw, rgw, ill;
    logic [1:0] rsrc, sa, sb;
    logic [3:0] aluc, st;
    logic [2:0] imm;
    int vectors = 0, miscompares = 0;
    int m_st = 0, m_cnt = 0;
    int m_seq[$];
    localparam logic [31:0] ADD = 32'h002081B3, LW = 32'h0000A183, SW = 32'h0020A023;
    localparam logic [31:0] BNE = 32'h00209463, JALRI = 32'h000080E7, BAD = 32'h0000007F;

    always #5 clk = ~clk;

    multicycle_control_v2 #(.ALUCTRL_W(4)
`ifdef CTRL_INSTRET_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_zero(zero), .i_lt(lt), .i_ltu(ltu),
        .i_mem_ready(rdy), .o_PCWrite(pcw), .o_AdrSrc(adr), .o_MemRead(mrd), .o_MemWrite(mwr),
        .o_IRWrite(irw), .o_RegWrite(rgw), .o_ResultSrc(rsrc), .o_ALUSrcA(sa), .o_ALUSrcB(sb),
        .o_ALUControl(aluc), .o_ImmSrc(imm), .o_illegal(ill), .o_state(st)
`ifdef CTRL_INSTRET_EN
        , .o_instret(instret)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (model state %0d, instr %08h, t=%0t)", name, act, exp, m_st, instr, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] i);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        case (i[6:0])
            7'h03: return f3 != 3'd3 && f3 < 3'd6;
            7'h23: return f3 < 3'd3;
            7'h33: return f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            7'h63: return f3 != 3'd2 && f3 != 3'd3;
            7'h13, 7'h6F, 7'h67, 7'h37, 7'h17: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // States an instruction visits after DECODE, by class
    function automatic void plan(input logic [31:0] i);
        if (!legal(i)) m_seq = '{14};
        else
            case (i[6:0])
                7'h03:   m_seq = '{2, 3, 4};
                7'h23:   m_seq = '{2, 5};
                7'h33:   m_seq = '{6, 8};
                7'h13:   m_seq = '{7, 8};
                7'h63:   m_seq = '{9};
                7'h6F:   m_seq = '{10, 8};
                7'h67:   m_seq = '{11, 12};
                default: m_seq = '{13, 8};
            endcase
    endfunction

    task automatic advance();
        if (m_st == 0) m_st = rdy ? 1 : 0;
        else if (m_st == 1) begin plan(instr); m_st = m_seq.pop_front(); end
        else if (m_st != 14 && !((m_st == 3 || m_st == 5) && !rdy)) begin
            m_st = m_seq.size() > 0 ? m_seq.pop_front() : 0;
            if (m_st == 0) m_cnt = (m_cnt + 1) % 16;
        end
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        return op == 7'h23 ? 3'd1 : op == 7'h63 ? 3'd2 : op == 7'h6F ? 3'd3 : (op == 7'h37 || op == 7'h17) ? 3'd4 : 3'd0;
    endfunction

    task automatic compare();
        logic [2:0] f3;
        logic [3:0] alu_tab[8];
        logic pw, ad, mr, mw, iw, rw, tk;
        logic [1:0] rs, a, b;
        logic [3:0] al;
        alu_tab = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        f3 = instr[14:12];
        {pw, ad, mr, mw, iw, rw, rs, a, b, al} = '0;
        tk = f3 == 0 ? opa == opb : f3 == 1 ? opa != opb : f3 == 4 ? $signed(opa) < $signed(opb) :
             f3 == 5 ? $signed(opa) >= $signed(opb) : f3 == 6 ? opa < opb : opa >= opb;
        if (!rst)
            case (m_st)
                0:  begin mr = 1; iw = rdy; pw = rdy; b = 2; rs = 2; end
                1:  begin a = 1; b = 1; end
                2:  begin a = 2; b = 1; end
                3:  begin ad = 1; mr = 1; end
                4:  begin rs = 1; rw = 1; end
                5:  begin ad = 1; mw = 1; end
                6, 7: begin
                    a = 2;
                    b = m_st == 7 ? 2'd1 : 2'd0;
                    al = alu_tab[f3] + ((instr[30] && (f3 == 5 || (f3 == 0 && m_st == 6))) ? 4'd1 : 4'd0);
                end
                8:  rw = 1;
                9:  begin a = 2; al = 1; pw = tk; end
                10: begin a = 1; b = 2; pw = 1; end
                11: begin a = 2; b = 1; rs = 3; rw = 1; end
                12: pw = 1;
                13: begin a = instr[6:0] == 7'h37 ? 2'd3 : 2'd1; b = 1; end
                default: ;
            endcase
        chk("state", st, m_st);
        chk("PCWrite", pcw, pw);
        chk("AdrSrc", adr, ad);
        chk("MemRead", mrd, mr);
        chk("MemWrite", mwr, mw);
        chk("IRWrite", irw, iw);
        chk("RegWrite", rgw, rw);
        chk("ResultSrc", rsrc, rs);
        chk("ALUSrcA", sa, a);
        chk("ALUSrcB", sb, b);
        chk("ALUControl", aluc, al);
        chk("ImmSrc", imm, rst ? 3'd0 : imm_of(instr[6:0]));
        chk("illegal", ill, !rst && m_st == 14);
`ifdef CTRL_INSTRET_EN
        chk("instret", instret, m_cnt % (1 << CW));
`endif
    endtask

    task automatic cycle(input logic r, input logic [31:0] ins, input logic rd,
                         input logic [31:0] a = 0, input logic [31:0] b = 0, input bit hold = 0);
        @(posedge clk);
        if (!rst) advance();
        @(negedge clk);
        rst = r;
        rdy = rd;
        opa = a;
        opb = b;
        zero = a == b;
        lt = $signed(a) < $signed(b);
        ltu = a < b;
        if (!hold || m_st == 0) instr = ins;
        if (r) begin m_st = 0; m_cnt = 0; m_seq = {}; end
        #1 compare();
    endtask

    function automatic logic [31:0] gen();
        logic [6:0] ops[10];
        logic [31:0] i;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
        i = $urandom;
        i[6:0] = ops[$urandom_range(0, 9)];
        if (i[6:0] == 7'h00) i[6:0] = 7'($urandom);
        if ($urandom_range(0, 3) != 0) i[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return i;
    endfunction

    initial begin
        logic [31:0] ra, rb;
        int tcnt;
        tcnt = 0;
        rst = 1;
        repeat (2) cycle(1, 0, 1);
        chk("rst_state", st, 0);
        chk("rst_enables", {pcw, mrd, mwr, irw, rgw, ill}, 0);
        cycle(0, ADD, 1);
        chk("add_fetch", {st, irw, pcw, mrd}, {4'd0, 3'b111});
        cycle(0, ADD, 1);
        chk("add_decode", {st, sa, sb}, {4'd1, 2'b01, 2'b01});
        cycle(0, ADD, 1);
        chk("add_execr", {st, aluc, rgw}, {4'd6, 4'd0, 1'b0});
        cycle(0, ADD, 1);
        chk("add_aluwb", {st, rgw, rsrc}, {4'd8, 1'b1, 2'b00});
        cycle(0, LW, 1);
        chk("lw_fetch_norgw", {st, rgw}, {4'd0, 1'b0});
        cycle(0, LW, 1);
        cycle(0, LW, 1);
        chk("lw_memadr", {st, sa, sb}, {4'd2, 2'b10, 2'b01});
        repeat (3) begin
            cycle(0, LW, 0);
            chk("lw_wait", {st, mrd, adr, rgw}, {4'd3, 3'b110});
        end
        cycle(0, LW, 1);
        chk("lw_ready", st, 3);
        cycle(0, LW, 1);
        chk("lw_memwb", {st, rgw, rsrc}, {4'd4, 1'b1, 2'b01});
        cycle(0, BNE, 1, 5, 5);
        cycle(0, BNE, 1, 5, 5);
        cycle(0, BNE, 1, 5, 5);
        chk("bne_equal", {st, pcw, imm}, {4'd9, 1'b0, 3'd2});
        cycle(0, BNE, 1, 5, 6);
        cycle(0, BNE, 1, 5, 6);
        cycle(0, BNE, 1, 5, 6);
        chk("bne_differ", {st, pcw, rsrc, aluc}, {4'd9, 1'b1, 2'b00, 4'd1});
        cycle(0, JALRI, 1);
        cycle(0, JALRI, 1);
        cycle(0, JALRI, 1);
        chk("jalr_link", {st, rgw, rsrc, pcw}, {4'd11, 1'b1, 2'b11, 1'b0});
        cycle(0, JALRI, 1);
        chk("jalr_pc", {st, pcw, rsrc, rgw}, {4'd12, 1'b1, 2'b00, 1'b0});
        cycle(0, BAD, 1);
        cycle(0, BAD, 1);
        chk("bad_decode", st, 1);
        repeat (3) begin
            cycle(0, BAD, 1);
            chk("trap_sticky", {st, ill, mrd, pcw, irw}, {4'd14, 4'b1000});
        end
        cycle(1, BAD, 1);
        chk("trap_reset", {st, ill}, 0);
        cycle(0, SW, 1);
        cycle(0, SW, 1);
        cycle(0, SW, 1);
        cycle(0, SW, 0);
        chk("sw_wait", {st, mwr, adr}, {4'd5, 2'b11});
        cycle(1, SW, 0);
        chk("sw_reset_drop", {st, mwr, adr}, 0);
`ifdef CTRL_INSTRET_EN
        repeat (17 * 4) cycle(0, ADD, 1);
        cycle(0, ADD, 0);
        chk("instret_wrap", instret, 1);
`endif
        for (int n = 0; n < 3000; n++) begin
            ra = $urandom;
            rb = $urandom_range(0, 2) == 0 ? ra : $urandom;
            tcnt = m_st == 14 ? tcnt + 1 : 0;
            cycle(tcnt > 3 || $urandom_range(0, 80) == 0, gen(), $urandom_range(0, 2) != 0, ra, rb, 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
